// File: rtl/neuron_pkg.sv
// Shared constants and types for the neuron datapath (Q12.20 sign-magnitude words).
package neuron_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned FRAC_BITS = 20;
    localparam int unsigned INT_BITS  = 12;
    localparam int unsigned GUARD_W   = 4;
    localparam int unsigned ACC_W     = WORD_W + GUARD_W;

    localparam logic [WORD_W-1:0] ONE    = 32'h0010_0000;
    localparam logic [WORD_W-1:0] SM_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        StAccum = 2'd0,
        StBias  = 2'd1,
        StOut   = 2'd2
    } acc_state_e;

endpackage

// File: rtl/sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter with sign extension.
module sm_to_tc
    import neuron_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned ACC_W = 36
) (
    input  logic [N-1:0]     sm,
    output logic [ACC_W-1:0] tc
);

    logic [ACC_W-1:0] mag;

    // Negative zero negates to zero, so it needs no special case.
    assign mag = {{(ACC_W-N+1){1'b0}}, sm[N-2:0]};
    assign tc  = sm[N-1] ? -mag : mag;

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates one neuron's weighted sum, adds bias, saturates to sign-magnitude.
// Define NEURON_ACC_RELU_EN to clamp negative results to zero during packing.
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned FRACBITS  = 20,
    parameter int unsigned GUARD     = 4,
    parameter int unsigned MAX_TERMS = 8,
    localparam int unsigned ACC_W    = N + GUARD,
    localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_ovf,
    input  logic             in_last,
    input  logic [N-1:0]     bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_terms
);

    if (FRACBITS >= N || (MAX_TERMS + 1) > (1 << GUARD)) begin : g_bad_cfg
        $error("neuron_accumulator: FRACBITS or GUARD/MAX_TERMS out of range");
    end

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_terms_q, out_terms_d;

    logic [ACC_W-1:0] in_tc, bias_tc, biased, res_mag;
    logic             res_neg, sat;
    logic [N-2:0]     mag_field;
    logic [N-1:0]     packed_data;

    sm_to_tc #(.N(N), .ACC_W(ACC_W)) u_in_conv (
        .sm (in_data),
        .tc (in_tc)
    );

    sm_to_tc #(.N(N), .ACC_W(ACC_W)) u_bias_conv (
        .sm (bias),
        .tc (bias_tc)
    );

    assign biased    = acc_q + bias_tc;
    assign res_neg   = biased[ACC_W-1];
    assign res_mag   = res_neg ? -biased : biased;
    assign sat       = |res_mag[ACC_W-1:N-1];
    assign mag_field = sat ? '1 : res_mag[N-2:0];

    // A negative result always has a non-zero magnitude, so zero never carries a sign.
`ifdef NEURON_ACC_RELU_EN
    assign packed_data = res_neg ? '0 : {1'b0, mag_field};
`else
    assign packed_data = {res_neg, mag_field};
`endif

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        term_cnt_d   = term_cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        out_terms_d  = out_terms_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        unique case (state_q)
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d        = acc_q + in_tc;
                    ovf_sticky_d = ovf_sticky_q | in_ovf;
                    term_cnt_d   = term_cnt_q + 1'b1;
                    if (in_last || term_cnt_q == CNT_W'(MAX_TERMS - 1)) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                acc_d       = biased;
                out_data_d  = packed_data;
                // Flag is per frame: multiplier overflows of this frame or saturation.
                out_ovf_d   = ovf_sticky_q | sat;
                out_terms_d = term_cnt_q;
                state_d     = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d        = '0;
                    term_cnt_d   = '0;
                    ovf_sticky_d = 1'b0;
                    state_d      = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccum;
            acc_q        <= '0;
            term_cnt_q   <= '0;
            ovf_sticky_q <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            out_terms_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            term_cnt_q   <= term_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            out_terms_q  <= out_terms_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_terms = out_terms_q;

endmodule
